ql_random_source: RTL and testbench

- Pseudo-random stimulus source feeding the Q-learning core: produces the random exploration action (`i_at_random`) and the episode start state (`i_first_st`).
- A single 16-bit Galois LFSR supplies both draws. Rejection sampling keeps every output inside its legal range.
- Requests come from the core's re-random strobe (action) and from the episode sequencer (first state).

---
 rtl/ql_random_source_if.sv | 50 +++++
 rtl/ql_random_source.sv | 189 ++++++++++++++++++
 tb/tb_ql_random_source.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ql_random_source_if.sv
// ql_random_source_if: request/response bundle of the random source.
// master = requester (drives seed/requests), slave = ql_random_source.
// QL_RNG_STATS_EN adds the o_reject_cnt statistics signal.
interface ql_random_source_if #(
  parameter int SW = 4,
  parameter int AW = 2
);
  logic          i_seed_load;
  logic [15:0]   i_seed;
  logic          i_req_action;
  logic          i_req_state;
  logic [AW-1:0] o_at_random;
  logic [SW-1:0] o_first_st;
  logic          o_action_valid;
  logic          o_state_valid;
  logic          o_busy;
`ifdef QL_RNG_STATS_EN
  logic [15:0]   o_reject_cnt;
`endif

  modport master (
`ifdef QL_RNG_STATS_EN
    input  o_reject_cnt,
`endif
    output i_seed_load,
    output i_seed,
    output i_req_action,
    output i_req_state,
    input  o_at_random,
    input  o_first_st,
    input  o_action_valid,
    input  o_state_valid,
    input  o_busy
  );

  modport slave (
`ifdef QL_RNG_STATS_EN
    output o_reject_cnt,
`endif
    input  i_seed_load,
    input  i_seed,
    input  i_req_action,
    input  i_req_state,
    output o_at_random,
    output o_first_st,
    output o_action_valid,
    output o_state_valid,
    output o_busy
  );
endinterface

// File: rtl/ql_random_source.sv
// ql_random_source: 16-bit Galois LFSR with rejection sampling that
// draws the exploration action and the episode start state.
// Ports: clk, rst_n (async low), bus (ql_random_source_if.slave):
//   i_seed_load/i_seed, i_req_action, i_req_state in;
//   o_at_random, o_first_st, o_action_valid, o_state_valid, o_busy out.
// Optional: QL_RNG_STATS_EN adds o_reject_cnt (saturating reject count).
module ql_random_source #(
  parameter int          STATES_WIDTH  = 4,
  parameter int          ACTIONS_WIDTH = 2,
  parameter int          NUM_STATES    = 12,
  parameter int          NUM_ACTIONS   = 3,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          MAX_TRIES     = 8
) (
  input logic              clk,
  input logic              rst_n,
  ql_random_source_if.slave bus
);

  localparam int          SW   = STATES_WIDTH;
  localparam int          AW   = ACTIONS_WIDTH;
  localparam int          TW   = $clog2(MAX_TRIES + 1);
  localparam logic [15:0] MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    DRAW_ACT,
    DRAW_ST
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   lfsr_nx;
  logic [TW-1:0] tries_q, tries_d;
  logic          pend_act_q, pend_act_d;
  logic          pend_st_q, pend_st_d;
  logic [AW-1:0] at_q, at_d;
  logic [SW-1:0] st_q, st_d;
  logic          av_q, av_d;
  logic          sv_q, sv_d;
  logic [AW-1:0] cand_a;
  logic [SW-1:0] cand_s;
  logic          ok_a, ok_s;
  logic          last_try;
  logic          done_a, done_s;
  logic          rej_inc;
  logic          req_a, req_s;

  assign req_a = bus.i_req_action;
  assign req_s = bus.i_req_state;

  always_comb begin
    lfsr_nx  = {1'b0, lfsr_q[15:1]}
             ^ (lfsr_q[0] ? MASK : 16'h0000);
    cand_a   = lfsr_nx[AW-1:0];
    cand_s   = lfsr_nx[SW-1:0];
    ok_a     = {1'b0, cand_a} < (AW+1)'(NUM_ACTIONS);
    ok_s     = {1'b0, cand_s} < (SW+1)'(NUM_STATES);
    // attempt number is tries_q+1; the last one forces a fallback
    last_try = tries_q == TW'(MAX_TRIES - 1);
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    tries_d = tries_q;
    at_d    = at_q;
    st_d    = st_q;
    av_d    = 1'b0;
    sv_d    = 1'b0;
    done_a  = 1'b0;
    done_s  = 1'b0;
    rej_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_act_q || req_a) begin
          state_d = DRAW_ACT;
        end else if (pend_st_q || req_s) begin
          state_d = DRAW_ST;
        end
      end
      DRAW_ACT: begin
        lfsr_d  = lfsr_nx;
        tries_d = tries_q + TW'(1);
        rej_inc = !ok_a;
        if (ok_a || last_try) begin
          at_d    = ok_a ? cand_a : '0;
          av_d    = 1'b1;
          done_a  = 1'b1;
          tries_d = '0;
          state_d = (pend_st_q || req_s)
                  ? DRAW_ST : IDLE;
        end
      end
      DRAW_ST: begin
        lfsr_d  = lfsr_nx;
        tries_d = tries_q + TW'(1);
        rej_inc = !ok_s;
        if (ok_s || last_try) begin
          st_d    = ok_s ? cand_s : '0;
          sv_d    = 1'b1;
          done_s  = 1'b1;
          tries_d = '0;
          state_d = (pend_act_q || req_a)
                  ? DRAW_ACT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pend_act_d = (pend_act_q && !done_a) || req_a;
    pend_st_d  = (pend_st_q && !done_s) || req_s;

    // seed load aborts everything and swallows same-cycle requests;
    // a zero seed would lock the LFSR, so SEED stands in for it
    if (bus.i_seed_load) begin
      lfsr_d     = (bus.i_seed == 16'h0000)
                 ? SEED : bus.i_seed;
      state_d    = IDLE;
      tries_d    = '0;
      pend_act_d = 1'b0;
      pend_st_d  = 1'b0;
      at_d       = at_q;
      st_d       = st_q;
      av_d       = 1'b0;
      sv_d       = 1'b0;
      rej_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      tries_q    <= '0;
      pend_act_q <= 1'b0;
      pend_st_q  <= 1'b0;
      at_q       <= '0;
      st_q       <= '0;
      av_q       <= 1'b0;
      sv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      tries_q    <= tries_d;
      pend_act_q <= pend_act_d;
      pend_st_q  <= pend_st_d;
      at_q       <= at_d;
      st_q       <= st_d;
      av_q       <= av_d;
      sv_q       <= sv_d;
    end
  end

  assign bus.o_at_random    = at_q;
  assign bus.o_first_st     = st_q;
  assign bus.o_action_valid = av_q;
  assign bus.o_state_valid  = sv_q;
  assign bus.o_busy         = (state_q != IDLE)
                            | pend_act_q | pend_st_q;

`ifdef QL_RNG_STATS_EN
  logic [15:0] rej_q, rej_d;

  always_comb begin
    rej_d = rej_q;
    if (bus.i_seed_load) begin
      rej_d = '0;
    end else if (rej_inc && rej_q != 16'hFFFF) begin
      rej_d = rej_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_q <= '0;
    end else begin
      rej_q <= rej_d;
    end
  end

  assign bus.o_reject_cnt = rej_q;
`else
  logic unused_rej;
  assign unused_rej = rej_inc;
`endif

endmodule

// File: tb/tb_ql_random_source.sv
// tb_ql_random_source: directed vector table, corner sequences and a
// randomized run against a behavioural model of the random source.
module tb_ql_random_source;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ql_random_source_if #(.SW(4), .AW(2)) bus ();
  ql_random_source_if #(.SW(4), .AW(2)) bus2 ();

  ql_random_source dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ql_random_source #(
    .NUM_ACTIONS (1),
    .MAX_TRIES   (2)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int got,
                     input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int x);
    return (x >> 1) ^ (((x & 1) != 0) ? 'hB400 : 0);
  endfunction

  task automatic tick(input bit ra, input bit rs,
                      input bit sl, input logic [15:0] sd);
    @(negedge clk);
    bus.i_req_action = ra;
    bus.i_req_state  = rs;
    bus.i_seed_load  = sl;
    bus.i_seed       = sd;
    @(posedge clk);
    #1;
    bus.i_req_action = 1'b0;
    bus.i_req_state  = 1'b0;
    bus.i_seed_load  = 1'b0;
    bus.i_seed       = 16'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ticks until the chosen valid pulses; returns draw cycles or -1
  task automatic wait_valid(input bit is_st, output int k);
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 16'h0);
      if ((is_st ? bus.o_state_valid : bus.o_action_valid)) begin
        k = i;
        break;
      end
    end
    if (k < 0) chk("valid_timeout", 0, 1);
  endtask

  typedef struct {
    bit is_st;
    int val;
    int k;
    int rej;
  } vec_t;

  vec_t vt[7];

  // behavioural model state: cur 0 = idle, 1 = action, 2 = state
  int m_lfsr, m_pa, m_ps, m_cur, m_tries;
  int m_at, m_st, m_av, m_sv, m_rej;

  task automatic m_reset();
    m_lfsr = 'hACE1; m_pa = 0; m_ps = 0; m_cur = 0;
    m_tries = 0; m_at = 0; m_st = 0; m_av = 0; m_sv = 0;
    m_rej = 0;
  endtask

  task automatic m_step(input bit ra, input bit rs,
                        input bit sl, input int sd);
    int nxt, lim, cand, da, ds;
    if (sl) begin
      m_lfsr = (sd == 0) ? 'hACE1 : sd;
      m_pa = 0; m_ps = 0; m_cur = 0; m_tries = 0;
      m_av = 0; m_sv = 0; m_rej = 0;
      return;
    end
    m_av = 0; m_sv = 0; da = 0; ds = 0; nxt = m_cur;
    if (m_cur == 0) begin
      if (m_pa != 0 || ra) nxt = 1;
      else if (m_ps != 0 || rs) nxt = 2;
    end else begin
      m_lfsr = lfsr_next(m_lfsr);
      m_tries++;
      lim  = (m_cur == 1) ? 3 : 12;
      cand = (m_cur == 1) ? m_lfsr % 4 : m_lfsr % 16;
      if (cand >= lim && m_rej < 65535) m_rej++;
      if (cand < lim || m_tries == 8) begin
        m_tries = 0;
        if (cand >= lim) cand = 0;
        if (m_cur == 1) begin
          m_at = cand; m_av = 1; da = 1;
          nxt = (m_ps != 0 || rs) ? 2 : 0;
        end else begin
          m_st = cand; m_sv = 1; ds = 1;
          nxt = (m_pa != 0 || ra) ? 1 : 0;
        end
      end
    end
    m_pa = ((m_pa != 0 && da == 0) || ra) ? 1 : 0;
    m_ps = ((m_ps != 0 && ds == 0) || rs) ? 1 : 0;
    m_cur = nxt;
  endtask

  initial begin
    int k;
    bit ra, rs, sl;
    logic [15:0] sd;
    int busy_exp;

    bus.i_req_action = 0; bus.i_req_state = 0;
    bus.i_seed_load = 0; bus.i_seed = 0;
    bus2.i_req_action = 0; bus2.i_req_state = 0;
    bus2.i_seed_load = 0; bus2.i_seed = 0;

    // draws from reset: E270,7138,389C,1C4E,(0E27,B313,ED89),C2C4,6162
    vt[0] = '{0, 0, 1, 0};
    vt[1] = '{0, 0, 1, 0};
    vt[2] = '{0, 0, 1, 0};
    vt[3] = '{0, 2, 1, 0};
    vt[4] = '{0, 1, 3, 2};
    vt[5] = '{1, 4, 1, 2};
    vt[6] = '{1, 2, 1, 2};

    // reset values
    #2;
    chk("rst_at", bus.o_at_random, 0);
    chk("rst_st", bus.o_first_st, 0);
    chk("rst_av", bus.o_action_valid, 0);
    chk("rst_sv", bus.o_state_valid, 0);
    chk("rst_busy", bus.o_busy, 0);
    do_reset();

    foreach (vt[i]) begin
      tick(!vt[i].is_st, vt[i].is_st, 0, 16'h0);
      chk($sformatf("v%0d_busy_req", i), bus.o_busy, 1);
      wait_valid(vt[i].is_st, k);
      chk($sformatf("v%0d_k", i), k, vt[i].k);
      chk($sformatf("v%0d_val", i),
          vt[i].is_st ? bus.o_first_st : bus.o_at_random,
          vt[i].val);
      chk($sformatf("v%0d_busy_done", i), bus.o_busy, 0);
`ifdef QL_RNG_STATS_EN
      chk($sformatf("v%0d_rej", i), bus.o_reject_cnt,
          vt[i].rej);
`endif
    end

    // simultaneous requests: action first, state one cycle later
    do_reset();
    tick(1, 1, 0, 16'h0);
    wait_valid(0, k);
    chk("dual_act_k", k, 1);
    chk("dual_act_val", bus.o_at_random, 0);
    chk("dual_sv_early", bus.o_state_valid, 0);
    tick(0, 0, 0, 16'h0);
    chk("dual_sv", bus.o_state_valid, 1);
    chk("dual_st_val", bus.o_first_st, 8);
    chk("dual_av_once", bus.o_action_valid, 0);

    // zero seed load in the middle of a multi-cycle action draw
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 16'h0);
      wait_valid(0, k);
    end
    chk("sl_pre_at", bus.o_at_random, 2);
    tick(1, 0, 0, 16'h0);
    tick(0, 0, 1, 16'h0);
    chk("sl_av", bus.o_action_valid, 0);
    chk("sl_busy", bus.o_busy, 0);
    chk("sl_hold_at", bus.o_at_random, 2);
    tick(0, 0, 0, 16'h0);
    chk("sl_av2", bus.o_action_valid, 0);
    tick(1, 0, 0, 16'h0);
    wait_valid(0, k);
    chk("sl_re_k", k, 1);
    chk("sl_re_val", bus.o_at_random, 0);
    tick(1, 0, 0, 16'h0);
    wait_valid(0, k);
    tick(1, 0, 0, 16'h0);
    wait_valid(0, k);
    tick(1, 0, 0, 16'h0);
    wait_valid(0, k);
    chk("sl_re_val4", bus.o_at_random, 2);

    // reset asserted during a state draw
    tick(0, 1, 0, 16'h0);
    chk("rmid_busy", bus.o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_at", bus.o_at_random, 0);
    chk("rmid_st", bus.o_first_st, 0);
    chk("rmid_busy0", bus.o_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 16'h0);
      if (bus.o_state_valid || bus.o_busy) k++;
    end
    chk("rmid_quiet", k, 0);

    // fallback: NUM_ACTIONS=1, MAX_TRIES=2, seed 389C -> 1C4E, 0E27
    @(negedge clk);
    bus2.i_seed_load = 1; bus2.i_seed = 16'h389C;
    @(posedge clk); #1;
    bus2.i_seed_load = 0; bus2.i_seed = 0;
    @(negedge clk);
    bus2.i_req_action = 1;
    @(posedge clk); #1;
    bus2.i_req_action = 0;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus2.o_action_valid) begin
        k = i;
        break;
      end
    end
    chk("fb_k", k, 2);
    chk("fb_val", bus2.o_at_random, 0);
`ifdef QL_RNG_STATS_EN
    chk("fb_rej", bus2.o_reject_cnt, 2);
`endif

    // randomized run against the model
    do_reset();
    m_reset();
    for (int c = 0; c < 400; c++) begin
      ra = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 5) == 0);
      sl = ($urandom_range(0, 39) == 0);
      sd = ($urandom_range(0, 3) == 0)
         ? 16'h0 : 16'($urandom);
      tick(ra, rs, sl, sd);
      m_step(ra, rs, sl, int'(sd));
      busy_exp = (m_cur != 0 || m_pa != 0 || m_ps != 0)
               ? 1 : 0;
      if (bus.o_action_valid != m_av[0] ||
          bus.o_state_valid != m_sv[0] ||
          bus.o_at_random != m_at[1:0] ||
          bus.o_first_st != m_st[3:0] ||
          bus.o_busy != busy_exp[0]) begin
        chk($sformatf("rnd_c%0d_av%0d_sv%0d_at%0d_st%0d_busy",
                      c, m_av, m_sv, m_at, m_st),
            {bus.o_action_valid, bus.o_state_valid,
             bus.o_at_random, bus.o_first_st, bus.o_busy},
            {m_av[0], m_sv[0], m_at[1:0], m_st[3:0],
             busy_exp[0]});
      end else begin
        n_tests++;
      end
`ifdef QL_RNG_STATS_EN
      chk("rnd_rej", bus.o_reject_cnt, m_rej);
`endif
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
